// File: rtl/l1_req_ctrl_seq_pkg.sv
// l1_req_ctrl_seq_pkg: MESI/snoop encodings, FSM states, fill helper.
// Shared by the request controller, its timer and its interface.
package l1_req_ctrl_seq_pkg;

  localparam logic [2:0] INVALID   = 3'd0;
  localparam logic [2:0] SHARED    = 3'd1;
  localparam logic [2:0] EXCLUSIVE = 3'd2;
  localparam logic [2:0] MODIFIED  = 3'd3;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;

  localparam logic [2:0] SURSP_SNOOP = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;

  localparam logic [2:0] CURSP_OK  = 3'd0;
  localparam logic [2:0] CURSP_ERR = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    SDREQ,
    WAIT_RSP,
    UPDATE,
    CPU_RSP
  } l1_req_seq_st_e;

  typedef struct packed {
    logic [2:0] st;
    logic       illegal;
  } l1_fill_t;

  // Next MESI state after a snoop response; writes always end Modified.
  function automatic l1_fill_t l1_miss_nxtSt(
    input logic       op,
    input logic [2:0] rsp
  );
    l1_fill_t r;
    r.st      = INVALID;
    r.illegal = 1'b0;
    unique case (1'b1)
      (rsp == SURSP_SNOOP): r.st = op ? MODIFIED : SHARED;
      (rsp == SURSP_FETCH): r.st = op ? MODIFIED : EXCLUSIVE;
      default:              r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l1_req_ctrl_seq_if.sv
// l1_req_ctrl_seq_if: CPU, lookup, writeback, snoop and stats signals.
// master = CPU/cache/bus side, slave = the request controller.
interface l1_req_ctrl_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  import l1_req_ctrl_seq_pkg::*;

  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_op;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic                  lkup_hit;
  logic [2:0]            lkup_blk_st;
  logic [2:0]            lkup_victim_st;
  logic [ADDR_WIDTH-1:0] lkup_victim_addr;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  sdreq_valid;
  logic                  sdreq_ready;
  logic [2:0]            sdreq_op;
  logic [ADDR_WIDTH-1:0] sdreq_addr;
  logic                  sursp_valid;
  logic [2:0]            sursp_rsp;
  logic                  blk_wr_en;
  logic [2:0]            blk_nxtSt;
  logic                  cpu_rsp_valid;
  logic                  cpu_rsp_ready;
  logic                  cpu_rsp_err;
  logic [CNT_WIDTH-1:0]  stat_hit_cnt;
  logic [CNT_WIDTH-1:0]  stat_miss_cnt;

  modport master (
    output cpu_req_valid, cpu_req_op, cpu_req_addr,
    output lkup_hit, lkup_blk_st,
    output lkup_victim_st, lkup_victim_addr,
    output wb_ready, sdreq_ready,
    output sursp_valid, sursp_rsp,
    output cpu_rsp_ready,
    input  cpu_req_ready,
    input  wb_valid, wb_addr,
    input  sdreq_valid, sdreq_op, sdreq_addr,
    input  blk_wr_en, blk_nxtSt,
    input  cpu_rsp_valid, cpu_rsp_err,
    input  stat_hit_cnt, stat_miss_cnt
  );

  modport slave (
    input  cpu_req_valid, cpu_req_op, cpu_req_addr,
    input  lkup_hit, lkup_blk_st,
    input  lkup_victim_st, lkup_victim_addr,
    input  wb_ready, sdreq_ready,
    input  sursp_valid, sursp_rsp,
    input  cpu_rsp_ready,
    output cpu_req_ready,
    output wb_valid, wb_addr,
    output sdreq_valid, sdreq_op, sdreq_addr,
    output blk_wr_en, blk_nxtSt,
    output cpu_rsp_valid, cpu_rsp_err,
    output stat_hit_cnt, stat_miss_cnt
  );

endinterface

// File: rtl/l1_req_ctrl_seq_timeout_ctr.sv
// l1_req_timeout_ctr: snoop response wait timer.
// expire is high once the count reaches TIMEOUT_CYCLES-1.
module l1_req_timeout_ctr
  import l1_req_ctrl_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [W-1:0] cnt;

  assign expire = (cnt == W'(TIMEOUT_CYCLES - 1));

  // Count while enabled, hold at the expiry value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/l1_req_ctrl_seq.sv
// l1_req_ctrl_seq: sequential L1 CPU request controller with MESI update.
// Define L1_REQ_STATS_EN to build the saturating hit/miss counters.
module l1_req_ctrl_seq
  import l1_req_ctrl_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2,
  parameter int CNT_WIDTH      = 16
) (
  input logic              clk,
  input logic              rst,
  l1_req_ctrl_seq_if.slave bus
);

  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  l1_req_seq_st_e state;
  logic           op_q;
  logic [RW-1:0]  retry;
  logic           tmr_clr;
  logic           tmr_en;
  logic           tmr_exp;
  l1_fill_t       fill;

  assign fill    = l1_miss_nxtSt(op_q, bus.sursp_rsp);
  assign tmr_en  = (state == WAIT_RSP);
  assign tmr_clr = (state == SDREQ) && bus.sdreq_ready;

  assign bus.cpu_req_ready = (state == IDLE);
  assign bus.wb_valid      = (state == WB);
  assign bus.sdreq_valid   = (state == SDREQ);
  assign bus.blk_wr_en     = (state == UPDATE);
  assign bus.cpu_rsp_valid = (state == CPU_RSP);

  l1_req_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_exp)
  );

  // Request sequencing: lookup, writeback, snoop, wait, commit, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      op_q            <= 1'b0;
      retry           <= '0;
      bus.wb_addr     <= '0;
      bus.sdreq_addr  <= '0;
      bus.sdreq_op    <= SDREQ_RD;
      bus.blk_nxtSt   <= INVALID;
      bus.cpu_rsp_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            op_q           <= bus.cpu_req_op;
            bus.sdreq_addr <= bus.cpu_req_addr;
            state          <= LOOKUP;
          end
        end
        LOOKUP: begin
          unique case (1'b1)
            (bus.lkup_hit && !op_q): begin
              bus.blk_nxtSt <= bus.lkup_blk_st;
              state         <= UPDATE;
            end
            (bus.lkup_hit && op_q &&
             bus.lkup_blk_st == SHARED): begin
              bus.sdreq_op <= SDREQ_INV;
              state        <= SDREQ;
            end
            (bus.lkup_hit && op_q &&
             bus.lkup_blk_st != SHARED): begin
              bus.blk_nxtSt <= MODIFIED;
              state         <= UPDATE;
            end
            default: begin
              bus.sdreq_op <= op_q ? SDREQ_RFO : SDREQ_RD;
              bus.wb_addr  <= bus.lkup_victim_addr;
              state <= (bus.lkup_victim_st == MODIFIED)
                       ? WB : SDREQ;
            end
          endcase
        end
        WB: begin
          if (bus.wb_ready) state <= SDREQ;
        end
        SDREQ: begin
          if (bus.sdreq_ready) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (bus.sursp_valid) begin
            if (fill.illegal) begin
              bus.cpu_rsp_err <= 1'b1;
              state           <= CPU_RSP;
            end else begin
              bus.blk_nxtSt <= fill.st;
              state         <= UPDATE;
            end
          end else if (tmr_exp) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= SDREQ;
            end else begin
              bus.cpu_rsp_err <= 1'b1;
              state           <= CPU_RSP;
            end
          end
        end
        UPDATE: begin
          state <= CPU_RSP;
        end
        CPU_RSP: begin
          if (bus.cpu_rsp_ready) begin
            bus.cpu_rsp_err <= 1'b0;
            retry           <= '0;
            state           <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef L1_REQ_STATS_EN
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  // Saturating hit/miss counts, one event per lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (bus.lkup_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign bus.stat_hit_cnt  = hit_cnt;
  assign bus.stat_miss_cnt = miss_cnt;
`else
  assign bus.stat_hit_cnt  = '0;
  assign bus.stat_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l1_req_ctrl_seq.sv
// tb_l1_req_ctrl_seq: directed and random requests checked against
// a transaction-level model of the controller's outcome.
`timescale 1ns/1ps
module tb_l1_req_ctrl_seq;
  import l1_req_ctrl_seq_pkg::*;

  localparam int AW   = 32;
  localparam int TO   = 8;
  localparam int MR   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_req_ctrl_seq_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  l1_req_ctrl_seq #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int ncomp = 0;
  int nfail = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  bit noise_en = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.cpu_req_valid = 1'b0;
    bus.wb_ready      = 1'b0;
    bus.sdreq_ready   = 1'b0;
    bus.sursp_valid   = 1'b0;
    bus.sursp_rsp     = 3'($urandom);
    bus.cpu_rsp_ready = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    check({nm, ".ready"}, bus.cpu_req_ready, 1);
    check({nm, ".wb_v"}, bus.wb_valid, 0);
    check({nm, ".sd_v"}, bus.sdreq_valid, 0);
    check({nm, ".wr_en"}, bus.blk_wr_en, 0);
    check({nm, ".rsp_v"}, bus.cpu_rsp_valid, 0);
    check({nm, ".err"}, bus.cpu_rsp_err, 0);
    check({nm, ".nxt"}, bus.blk_nxtSt, INVALID);
    check({nm, ".sd_op"}, bus.sdreq_op, SDREQ_RD);
    check({nm, ".wb_a"}, bus.wb_addr, 0);
    check({nm, ".sd_a"}, bus.sdreq_addr, 0);
    check({nm, ".hits"}, bus.stat_hit_cnt, 0);
    check({nm, ".miss"}, bus.stat_miss_cnt, 0);
  endtask

  // Expected outcome of one request from the MESI/snoop rules.
  function automatic void model(
    input bit op, input bit hit,
    input logic [2:0] blk, input logic [2:0] vict,
    input bit has_rsp, input logic [2:0] code,
    input int rsp_issue,
    output int e_wb, output int e_iss,
    output int e_commit, output int e_err,
    output logic [2:0] e_op, output logic [2:0] e_nxt);
    bit need;
    need = !hit || (op && blk == SHARED);
    e_wb = (!hit && vict == MODIFIED) ? 1 : 0;
    e_op = hit ? SDREQ_INV : (op ? SDREQ_RFO : SDREQ_RD);
    e_nxt = INVALID;
    e_commit = 0;
    e_err = 0;
    e_iss = 0;
    if (!need) begin
      e_commit = 1;
      e_nxt = op ? MODIFIED : blk;
    end else if (!has_rsp) begin
      e_iss = MR + 1;
      e_err = 1;
    end else begin
      e_iss = rsp_issue + 1;
      if (code == SURSP_SNOOP || code == SURSP_FETCH) begin
        e_commit = 1;
        if (op) e_nxt = MODIFIED;
        else if (code == SURSP_SNOOP) e_nxt = SHARED;
        else e_nxt = EXCLUSIVE;
      end else begin
        e_err = 1;
      end
    end
  endfunction

  task automatic txn(
    input string nm, input bit op, input logic [31:0] addr,
    input bit hit, input logic [2:0] blk,
    input logic [2:0] vict, input logic [31:0] vaddr,
    input bit has_rsp, input logic [2:0] code,
    input int rsp_issue, input int rsp_dly,
    input int sd_stall, input int wb_stall, input int rsp_stall);
    int e_wb, e_iss, e_commit, e_err;
    logic [2:0] e_op, e_nxt, got_nxt;
    int cyc, wbs, iss, commits, lat, sdw, wbw, rspw, wcyc;
    bit in_wait, done, seen;
    model(op, hit, blk, vict, has_rsp, code, rsp_issue,
          e_wb, e_iss, e_commit, e_err, e_op, e_nxt);
    @(negedge clk);
    quiet();
    check({nm, ".req_rdy"}, bus.cpu_req_ready, 1);
    bus.cpu_req_valid    = 1'b1;
    bus.cpu_req_op       = op;
    bus.cpu_req_addr     = addr;
    bus.lkup_hit         = hit;
    bus.lkup_blk_st      = blk;
    bus.lkup_victim_st   = vict;
    bus.lkup_victim_addr = vaddr;
    @(posedge clk);
    wbs = 0; iss = 0; commits = 0; lat = 0;
    sdw = 0; wbw = 0; rspw = 0; wcyc = 0;
    in_wait = 0; done = 0; seen = 0;
    got_nxt = 3'bx;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      quiet();
      if (noise_en && !in_wait)
        bus.sursp_valid = 1'($urandom_range(0, 1));
      if (bus.wb_valid) begin
        check({nm, ".wb_addr"}, bus.wb_addr, vaddr);
        if (wbw >= wb_stall) begin
          bus.wb_ready = 1'b1;
          wbs++;
        end
        wbw++;
      end
      if (bus.sdreq_valid) begin
        if (in_wait) begin
          check({nm, ".wait_len"}, wcyc, TO);
          in_wait = 0;
        end
        if (sdw == 0) check({nm, ".wb_first"}, wbs, e_wb);
        check({nm, ".sd_op"}, bus.sdreq_op, e_op);
        check({nm, ".sd_addr"}, bus.sdreq_addr, addr);
        if (sdw >= sd_stall) begin
          bus.sdreq_ready = 1'b1;
          iss++;
          in_wait = 1;
          wcyc = 0;
          sdw = 0;
        end else begin
          sdw++;
        end
      end else if (in_wait) begin
        if (has_rsp && iss == rsp_issue + 1 && wcyc == rsp_dly) begin
          bus.sursp_valid = 1'b1;
          bus.sursp_rsp   = code;
          in_wait = 0;
        end
        wcyc++;
      end
      if (bus.blk_wr_en) begin
        commits++;
        got_nxt = bus.blk_nxtSt;
      end
      if (bus.cpu_rsp_valid) begin
        if (!seen) begin
          seen = 1;
          lat = cyc;
        end
        check({nm, ".err"}, bus.cpu_rsp_err, e_err);
        if (rspw >= rsp_stall) begin
          bus.cpu_rsp_ready = 1'b1;
          done = 1;
        end
        rspw++;
      end
      cyc++;
    end
    check({nm, ".done"}, done, 1);
    @(negedge clk);
    quiet();
    check({nm, ".rsp_drop"}, bus.cpu_rsp_valid, 0);
    check({nm, ".idle_rdy"}, bus.cpu_req_ready, 1);
    check({nm, ".wbs"}, wbs, e_wb);
    check({nm, ".issues"}, iss, e_iss);
    check({nm, ".commits"}, commits, e_commit);
    if (e_commit == 1) check({nm, ".nxt"}, got_nxt, e_nxt);
    if (e_iss == 0 && rsp_stall == 0) check({nm, ".lat"}, lat, 3);
`ifdef L1_REQ_STATS_EN
    if (hit) begin
      if (exp_hit < CMAX) exp_hit++;
    end else begin
      if (exp_miss < CMAX) exp_miss++;
    end
`endif
    check({nm, ".st_hit"}, bus.stat_hit_cnt, exp_hit);
    check({nm, ".st_miss"}, bus.stat_miss_cnt, exp_miss);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    bus.cpu_req_op       = 1'b0;
    bus.cpu_req_addr     = '0;
    bus.lkup_hit         = 1'b0;
    bus.lkup_blk_st      = INVALID;
    bus.lkup_victim_st   = INVALID;
    bus.lkup_victim_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    txn("rdhitE", 0, 32'h80, 1, EXCLUSIVE, INVALID, 0,
        0, 0, 0, 0, 0, 0, 0);
    txn("wrhitE", 1, 32'h84, 1, EXCLUSIVE, INVALID, 0,
        0, 0, 0, 0, 0, 0, 0);
    txn("wrhitS", 1, 32'h1240, 1, SHARED, INVALID, 0,
        1, SURSP_SNOOP, 0, 2, 4, 0, 1);
    txn("rdmisF", 0, 32'h2000, 0, INVALID, MODIFIED, 32'h1000,
        1, SURSP_FETCH, 0, 1, 0, 2, 0);
    txn("rdmisS", 0, 32'h2040, 0, INVALID, MODIFIED, 32'h1000,
        1, SURSP_SNOOP, 0, 3, 1, 0, 0);
    txn("wrtout", 1, 32'h3000, 0, INVALID, EXCLUSIVE, 32'h5000,
        0, 0, 0, 0, 0, 0, 0);
    txn("race0", 1, 32'h3100, 0, INVALID, SHARED, 32'h5100,
        1, SURSP_FETCH, 0, TO - 1, 0, 0, 0);
    txn("race1", 0, 32'h3200, 0, INVALID, INVALID, 32'h5200,
        1, SURSP_SNOOP, 1, TO - 1, 0, 0, 0);
    txn("illeg", 0, 32'h4000, 0, INVALID, INVALID, 0,
        1, 3'b111, 0, 0, 0, 0, 0);

    // Abandon a write miss while it waits for its snoop response.
    @(negedge clk);
    quiet();
    bus.cpu_req_valid  = 1'b1;
    bus.cpu_req_op     = 1'b1;
    bus.cpu_req_addr   = 32'h7700;
    bus.lkup_hit       = 1'b0;
    bus.lkup_victim_st = INVALID;
    @(negedge clk);
    quiet();
    @(negedge clk);
    quiet();
    check("mid.sd_v", bus.sdreq_valid, 1);
    bus.sdreq_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      quiet();
    end
    rst = 1'b1;
    @(negedge clk);
    quiet();
    check_reset("rstmid");
    rst = 1'b0;
    exp_hit = 0;
    exp_miss = 0;

    txn("st_h1", 0, 32'h10, 1, SHARED, INVALID, 0,
        0, 0, 0, 0, 0, 0, 0);
    txn("st_m1", 0, 32'h20, 0, INVALID, INVALID, 0,
        1, SURSP_FETCH, 0, 0, 0, 0, 0);
    txn("st_h2", 1, 32'h30, 1, MODIFIED, INVALID, 0,
        0, 0, 0, 0, 0, 0, 0);
    txn("st_m2", 1, 32'h40, 0, INVALID, MODIFIED, 32'h9000,
        1, SURSP_SNOOP, 0, 2, 0, 1, 0);
    txn("st_h3", 0, 32'h50, 1, MODIFIED, INVALID, 0,
        0, 0, 0, 0, 0, 0, 0);

    noise_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bit rop, rhit, rhas;
      logic [2:0] rblk, rvict, rcode;
      int sel;
      rop   = 1'($urandom_range(0, 1));
      rhit  = 1'($urandom_range(0, 1));
      rblk  = 3'($urandom_range(1, 3));
      rvict = 3'($urandom_range(0, 3));
      rhas  = ($urandom_range(0, 3) != 0);
      sel   = $urandom_range(0, 9);
      if (sel < 4) rcode = SURSP_SNOOP;
      else if (sel < 8) rcode = SURSP_FETCH;
      else rcode = 3'($urandom_range(2, 7));
      txn("rnd", rop, $urandom, rhit, rblk, rvict, $urandom,
          rhas, rcode, $urandom_range(0, MR),
          $urandom_range(0, TO - 1), $urandom_range(0, 2),
          $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
